// File: rtl/uart_tx_arbiter.sv
// Message-granular round-robin arbiter: NUM_SRC AXI-Stream byte sources share one UART TX
// byte stream. Define UART_ARB_TIMEOUT_EN to force-release grants held by stalled sources.
module uart_tx_arbiter #(
  parameter int unsigned NUM_SRC        = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [8*NUM_SRC-1:0]       s_axis_tdata,
  input  logic [NUM_SRC-1:0]         s_axis_tvalid,
  output logic [NUM_SRC-1:0]         s_axis_tready,
  input  logic [NUM_SRC-1:0]         s_axis_tlast,
  output logic [7:0]                 uart_axis_tdata,
  output logic                       uart_axis_tvalid,
  input  logic                       uart_axis_tready,
  output logic [$clog2(NUM_SRC)-1:0] grant_id,
  output logic                       grant_active,
  output logic                       timeout_pulse
);
  localparam int unsigned IdW = $clog2(NUM_SRC);

  if (NUM_SRC < 2 || NUM_SRC > 16 || TIMEOUT_CYCLES < 2) begin : gen_param_err
    $error("uart_tx_arbiter: parameter out of range");
  end

  typedef enum logic [0:0] {StIdle, StLocked} state_e;

  state_e         state_q, state_d;
  logic [IdW-1:0] grant_q, grant_d;
  logic [IdW-1:0] rr_ptr_q, rr_ptr_d;
  logic [7:0]     data_q, data_d;
  logic           valid_q, valid_d;
  logic [7:0]     src_data [NUM_SRC];
  logic [IdW-1:0] pick;
  logic           pick_found;
  logic           load_ok;
  logic           accept;
  logic           timeout_hit;
  logic [IdW-1:0] ptr_after_grant;

  for (genvar i = 0; i < NUM_SRC; i++) begin : gen_unpack
    assign src_data[i] = s_axis_tdata[8*i +: 8];
  end

  // First valid source at or above rr_ptr, wrapping to 0.
  always_comb begin
    logic [IdW-1:0] idx;
    idx        = '0;
    pick       = rr_ptr_q;
    pick_found = 1'b0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      idx = IdW'((32'(rr_ptr_q) + i) % NUM_SRC);
      if (!pick_found && s_axis_tvalid[idx]) begin
        pick_found = 1'b1;
        pick       = idx;
      end
    end
  end

  assign load_ok         = !valid_q || uart_axis_tready;
  assign accept          = (state_q == StLocked) && s_axis_tvalid[grant_q] && load_ok;
  assign ptr_after_grant = (grant_q == IdW'(NUM_SRC - 1)) ? '0 : grant_q + 1'b1;

  always_comb begin
    s_axis_tready = '0;
    if (state_q == StLocked) s_axis_tready[grant_q] = load_ok;
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    valid_d  = valid_q;
    data_d   = data_q;
    // Drain and reload in the same cycle keeps one byte per cycle.
    if (accept) begin
      valid_d = 1'b1;
      data_d  = src_data[grant_q];
    end else if (uart_axis_tready) begin
      valid_d = 1'b0;
    end
    unique case (state_q)
      StIdle: begin
        if (pick_found) begin
          grant_d = pick;
          state_d = StLocked;
        end
      end
      StLocked: begin
        if ((accept && s_axis_tlast[grant_q]) || timeout_hit) begin
          state_d  = StIdle;
          rr_ptr_d = ptr_after_grant;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      valid_q  <= 1'b0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CntW-1:0] idle_cnt_q, idle_cnt_d;
  logic            pulse_q;

  // Counts cycles the granted source leaves tvalid low; holds while stalled by the output.
  always_comb begin
    idle_cnt_d  = '0;
    timeout_hit = 1'b0;
    if (state_q == StLocked) begin
      if (!s_axis_tvalid[grant_q]) begin
        if (idle_cnt_q == CntW'(TIMEOUT_CYCLES - 1)) timeout_hit = 1'b1;
        else idle_cnt_d = idle_cnt_q + 1'b1;
      end else if (!accept) begin
        idle_cnt_d = idle_cnt_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idle_cnt_q <= '0;
      pulse_q    <= 1'b0;
    end else begin
      idle_cnt_q <= idle_cnt_d;
      pulse_q    <= timeout_hit;
    end
  end

  assign timeout_pulse = pulse_q;
`else
  assign timeout_hit   = 1'b0;
  assign timeout_pulse = 1'b0;
`endif

  assign uart_axis_tdata  = data_q;
  assign uart_axis_tvalid = valid_q;
  assign grant_id         = grant_q;
  assign grant_active     = (state_q == StLocked);

endmodule
